// File: rtl/uart_prog_loader.sv
// UART program loader and run controller for the pipelined MIPS datapath.
// Receives 8N1 bytes on rx, decodes LOAD/RUN/STEP/HALT/CLRERR commands,
// writes loaded instruction words to instruction memory and drives the
// pipeline latch enable.
// Optional: define LOADER_CHECKSUM_EN to require an XOR checksum byte after
// the last LOAD word.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   rx         UART serial input, idle high, asynchronous to clk
//   imem_we    instruction-memory write strobe (one cycle per word)
//   imem_addr  byte address of the written word (multiple of 4)
//   imem_wdata instruction word
//   le         pipeline latch enable
//   busy       high while a LOAD transfer is in progress
//   rx_err     sticky framing / checksum error flag
module uart_prog_loader #(
    parameter int unsigned BAUD_DIV = 326,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              le,
    output logic              busy,
    output logic              rx_err
);

    localparam int unsigned DIV_W = $clog2(BAUD_DIV);
    localparam int unsigned IDX_W = ADDR_W - 2;

    // 16x oversample tick, free running
    logic [DIV_W-1:0] div_cnt;
    logic             tick_c;

    assign tick_c = (div_cnt == DIV_W'(BAUD_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      div_cnt <= '0;
        else if (tick_c) div_cnt <= '0;
        else             div_cnt <= div_cnt + DIV_W'(1);
    end

    // 2-flop synchroniser plus one delayed copy for edge detection
    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // RX deserialiser
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    rx_state_t  rx_state, rx_state_nxt;
    logic [3:0] os_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic       byte_v_c, frm_err_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rx_state <= RX_IDLE;
        else        rx_state <= rx_state_nxt;
    end

    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_sync) rx_state_nxt = RX_START;
            // mid-start re-check; a high line here was only a glitch
            RX_START: if (tick_c && os_cnt == 4'd7)
                          rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick_c && os_cnt == 4'd15 && bit_cnt == 3'd7)
                          rx_state_nxt = RX_STOP;
            RX_STOP:  if (tick_c && os_cnt == 4'd15) rx_state_nxt = RX_IDLE;
            default:  rx_state_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        byte_v_c  = 1'b0;
        frm_err_c = 1'b0;
        if (rx_state == RX_STOP && tick_c && os_cnt == 4'd15) begin
            byte_v_c  = rx_sync;
            frm_err_c = !rx_sync;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            os_cnt   <= '0;
            bit_cnt  <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    os_cnt  <= '0;
                    bit_cnt <= '0;
                end
                RX_START: if (tick_c) os_cnt <= (os_cnt == 4'd7) ? 4'd0 : os_cnt + 4'd1;
                RX_DATA: if (tick_c) begin
                    os_cnt <= os_cnt + 4'd1;
                    if (os_cnt == 4'd15) begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        bit_cnt  <= bit_cnt + 3'd1;
                    end
                end
                RX_STOP: if (tick_c) os_cnt <= os_cnt + 4'd1;
                default: os_cnt <= '0;
            endcase
        end
    end

    // Command FSM
    typedef enum logic [2:0] {
        C_IDLE, C_CNT_HI, C_CNT_LO, C_DATA
`ifdef LOADER_CHECKSUM_EN
        , C_CHK
`endif
    } cmd_state_t;

    cmd_state_t        cmd_state, cmd_state_nxt;
    logic [7:0]        cnt_hi, cnt_hi_nxt;
    logic [CNT_W-1:0]  words_left, words_left_nxt, count_c;
    logic [23:0]       word_buf, word_buf_nxt;
    logic [1:0]        byte_idx, byte_idx_nxt;
    logic [IDX_W-1:0]  index, index_nxt;
    logic              step_pend, step_pend_nxt;
    logic              imem_we_nxt, le_nxt, busy_nxt, rx_err_nxt;
    logic [ADDR_W-1:0] imem_addr_nxt;
    logic [31:0]       imem_wdata_nxt;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        chk, chk_nxt;
`endif

    assign count_c = CNT_W'({cnt_hi, rx_shift});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cmd_state <= C_IDLE;
        else        cmd_state <= cmd_state_nxt;
    end

    // Loads end in IDLE, or in CHK when the checksum byte is required
    always_comb begin
        cmd_state_nxt = cmd_state;
        if (byte_v_c) begin
            case (cmd_state)
                C_IDLE:   if (rx_shift == 8'h01) cmd_state_nxt = C_CNT_HI;
                C_CNT_HI: cmd_state_nxt = C_CNT_LO;
                C_CNT_LO:
`ifdef LOADER_CHECKSUM_EN
                    cmd_state_nxt = (count_c == '0) ? C_CHK : C_DATA;
`else
                    cmd_state_nxt = (count_c == '0) ? C_IDLE : C_DATA;
`endif
                C_DATA:
                    if (byte_idx == 2'd3 && words_left == CNT_W'(1))
`ifdef LOADER_CHECKSUM_EN
                        cmd_state_nxt = C_CHK;
`else
                        cmd_state_nxt = C_IDLE;
`endif
                default:  cmd_state_nxt = C_IDLE;
            endcase
        end
    end

    // Next values of registered outputs and loader datapath
    always_comb begin
        imem_we_nxt    = 1'b0;
        imem_addr_nxt  = imem_addr;
        imem_wdata_nxt = imem_wdata;
        le_nxt         = le;
        busy_nxt       = busy;
        rx_err_nxt     = rx_err;
        cnt_hi_nxt     = cnt_hi;
        words_left_nxt = words_left;
        word_buf_nxt   = word_buf;
        byte_idx_nxt   = byte_idx;
        index_nxt      = index;
        step_pend_nxt  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        chk_nxt        = chk;
`endif
        // a single step holds le for exactly one cycle
        if (step_pend) le_nxt = 1'b0;
        if (frm_err_c) rx_err_nxt = 1'b1;
        if (byte_v_c) begin
            case (cmd_state)
                C_IDLE: begin
                    case (rx_shift)
                        8'h01: begin
                            le_nxt   = 1'b0;
                            busy_nxt = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                            chk_nxt  = '0;
`endif
                        end
                        8'h02: le_nxt = 1'b1;
                        8'h03: if (!le) begin
                            le_nxt        = 1'b1;
                            step_pend_nxt = 1'b1;
                        end
                        8'h04: le_nxt = 1'b0;
                        8'h05: rx_err_nxt = 1'b0;
                        default: ;
                    endcase
                end
                C_CNT_HI: cnt_hi_nxt = rx_shift;
                C_CNT_LO: begin
                    words_left_nxt = count_c;
                    byte_idx_nxt   = '0;
`ifndef LOADER_CHECKSUM_EN
                    if (count_c == '0) busy_nxt = 1'b0;
`endif
                end
                C_DATA: begin
                    word_buf_nxt = {word_buf[15:0], rx_shift};
                    byte_idx_nxt = byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    chk_nxt      = chk ^ rx_shift;
`endif
                    if (byte_idx == 2'd3) begin
                        imem_we_nxt    = 1'b1;
                        imem_addr_nxt  = {index, 2'b00};
                        imem_wdata_nxt = {word_buf, rx_shift};
                        words_left_nxt = words_left - CNT_W'(1);
                        if (words_left == CNT_W'(1)) begin
                            index_nxt = '0;
`ifndef LOADER_CHECKSUM_EN
                            busy_nxt  = 1'b0;
`endif
                        end else begin
                            index_nxt = index + IDX_W'(1);
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                C_CHK: begin
                    busy_nxt = 1'b0;
                    if (rx_shift != chk) rx_err_nxt = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            le         <= 1'b0;
            busy       <= 1'b0;
            rx_err     <= 1'b0;
            cnt_hi     <= '0;
            words_left <= '0;
            word_buf   <= '0;
            byte_idx   <= '0;
            index      <= '0;
            step_pend  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk        <= '0;
`endif
        end else begin
            imem_we    <= imem_we_nxt;
            imem_addr  <= imem_addr_nxt;
            imem_wdata <= imem_wdata_nxt;
            le         <= le_nxt;
            busy       <= busy_nxt;
            rx_err     <= rx_err_nxt;
            cnt_hi     <= cnt_hi_nxt;
            words_left <= words_left_nxt;
            word_buf   <= word_buf_nxt;
            byte_idx   <= byte_idx_nxt;
            index      <= index_nxt;
            step_pend  <= step_pend_nxt;
`ifdef LOADER_CHECKSUM_EN
            chk        <= chk_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: directed UART frames, a table of
// single-byte command vectors, and hand-written LOAD / glitch / reset sequences.
module tb_uart_prog_loader;

    localparam int unsigned BAUD_DIV = 3;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned BIT_CLKS = 16 * BAUD_DIV;
`ifdef LOADER_CHECKSUM_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              rx;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              le;
    logic              busy;
    logic              rx_err;

    always #5 clk = ~clk;

    uart_prog_loader #(.BAUD_DIV(BAUD_DIV), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .le         (le),
        .busy       (busy),
        .rx_err     (rx_err)
    );

    int n_vec = 0;
    int n_bad = 0;

    // write log and le-high cycle counter, sampled on the falling edge
    logic [ADDR_W-1:0] wr_addr [64];
    logic [31:0]       wr_data [64];
    logic              wr_busy [64];
    int                wr_cnt = 0;
    int                le_hi_total = 0;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr[wr_cnt % 64] = imem_addr;
            wr_data[wr_cnt % 64] = imem_wdata;
            wr_busy[wr_cnt % 64] = busy;
            wr_cnt = wr_cnt + 1;
        end
        if (le) le_hi_total = le_hi_total + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = stop;
        repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_write(input string name, input int idx, input logic [ADDR_W-1:0] ea,
                               input logic [31:0] ed);
        chk({name, "_addr"}, 32'(wr_addr[idx % 64]), 32'(ea));
        chk({name, "_data"}, wr_data[idx % 64], ed);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_le;
        logic       exp_busy;
        logic       exp_err;
        int         exp_le_hi;   // -1: not checked
    } vec_t;

    vec_t vt [11];

    initial begin
        int base_wr;
        int base_hi;

        vt[0]  = '{8'h02, 1'b1, 1'b1, 1'b0,   1'b0, -1};  // RUN
        vt[1]  = '{8'h03, 1'b1, 1'b1, 1'b0,   1'b0, -1};  // STEP while running: ignored
        vt[2]  = '{8'h04, 1'b1, 1'b0, 1'b0,   1'b0, -1};  // HALT
        vt[3]  = '{8'h03, 1'b1, 1'b0, 1'b0,   1'b0,  1};  // STEP: one-cycle pulse
        vt[4]  = '{8'h02, 1'b0, 1'b0, 1'b0,   1'b1,  0};  // RUN with bad stop bit
        vt[5]  = '{8'h07, 1'b1, 1'b0, 1'b0,   1'b1,  0};  // unknown byte
        vt[6]  = '{8'h05, 1'b1, 1'b0, 1'b0,   1'b0,  0};  // CLRERR
        vt[7]  = '{8'h02, 1'b1, 1'b1, 1'b0,   1'b0, -1};  // RUN
        vt[8]  = '{8'h01, 1'b1, 1'b0, 1'b1,   1'b0, -1};  // LOAD while running
        vt[9]  = '{8'h00, 1'b1, 1'b0, 1'b1,   1'b0,  0};  // count hi
        vt[10] = '{8'h00, 1'b1, 1'b0, CHK_EN, 1'b0,  0};  // count lo, N=0

        reset = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_le", 32'(le), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(rx_err), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        // LOAD of two words
        base_wr = wr_cnt;
        base_hi = le_hi_total;
        send_byte(8'h01, 1'b1);
        chk("load_busy_start", 32'(busy), 32'd1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h20, 1'b1);
        send_byte(8'h08, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h08, 1'b1);
        chk("load_nwr", 32'(wr_cnt - base_wr), 32'd2);
        check_write("load_w0", base_wr, 4'h0, 32'h2008_0005);
        check_write("load_w1", base_wr + 1, 4'h4, 32'h0000_0008);
        chk("load_w0_busy", 32'(wr_busy[base_wr % 64]), 32'd1);
        chk("load_w1_busy", 32'(wr_busy[(base_wr + 1) % 64]), 32'(CHK_EN));
        chk("load_le_hi", 32'(le_hi_total - base_hi), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h25, 1'b1);
        chk("load_chk_busy", 32'(busy), 32'd0);
        chk("load_chk_err", 32'(rx_err), 32'd0);
`else
        chk("load_end_busy", 32'(busy), 32'd0);
`endif

        // single-byte command table
        for (int i = 0; i < 11; i++) begin
            base_hi = le_hi_total;
            send_byte(vt[i].data, vt[i].stop);
            chk($sformatf("vec%0d_le", i), 32'(le), 32'(vt[i].exp_le));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].exp_busy));
            chk($sformatf("vec%0d_err", i), 32'(rx_err), 32'(vt[i].exp_err));
            if (vt[i].exp_le_hi >= 0)
                chk($sformatf("vec%0d_le_hi", i), 32'(le_hi_total - base_hi),
                    32'(vt[i].exp_le_hi));
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00, 1'b1);
        chk("n0_chk_busy", 32'(busy), 32'd0);
        chk("n0_chk_err", 32'(rx_err), 32'd0);
`endif

        // short low glitch must not start a frame
        @(negedge clk);
        rx = 1'b0;
        repeat ((BIT_CLKS * 3) / 10) @(negedge clk);
        rx = 1'b1;
        repeat (12 * BIT_CLKS) @(negedge clk);
        chk("glitch_le", 32'(le), 32'd0);
        chk("glitch_err", 32'(rx_err), 32'd0);
        send_byte(8'h02, 1'b1);
        chk("glitch_run_le", 32'(le), 32'd1);
        send_byte(8'h04, 1'b1);
        chk("glitch_halt_le", 32'(le), 32'd0);

        // five words into a 4-word address space wrap back to 0
        base_wr = wr_cnt;
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h05, 1'b1);
        for (int w = 0; w < 5; w++)
            for (int b = 0; b < 4; b++)
                send_byte(8'h10 + 8'(w), 1'b1);
        chk("wrap_nwr", 32'(wr_cnt - base_wr), 32'd5);
        for (int w = 0; w < 5; w++)
            check_write($sformatf("wrap_w%0d", w), base_wr + w, 4'((w * 4) % 16),
                        {4{8'h10 + 8'(w)}});
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00, 1'b1);
`endif
        chk("wrap_busy", 32'(busy), 32'd0);
        chk("wrap_err", 32'(rx_err), 32'd0);

        // reset in the middle of a LOAD, with a dropped bad frame pending
        base_wr = wr_cnt;
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b0);
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_err", 32'(rx_err), 32'd1);
        chk("mid_nwr", 32'(wr_cnt - base_wr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("arst_le", 32'(le), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_err", 32'(rx_err), 32'd0);
        chk("arst_we", 32'(imem_we), 32'd0);
        chk("arst_wdata", imem_wdata, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        base_wr = wr_cnt;
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        chk("fresh_nwr", 32'(wr_cnt - base_wr), 32'd1);
        check_write("fresh_w0", base_wr, 4'h0, 32'hDEAD_BEEF);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h22, 1'b1);
        chk("fresh_chk_err", 32'(rx_err), 32'd0);

        // checksum match then mismatch
        for (int r = 0; r < 2; r++) begin
            base_wr = wr_cnt;
            send_byte(8'h01, 1'b1);
            send_byte(8'h00, 1'b1);
            send_byte(8'h01, 1'b1);
            send_byte(8'h11, 1'b1);
            send_byte(8'h22, 1'b1);
            send_byte(8'h33, 1'b1);
            send_byte(8'h44, 1'b1);
            chk($sformatf("cks%0d_pre_busy", r), 32'(busy), 32'd1);
            send_byte(8'h44 + 8'(r), 1'b1);
            check_write($sformatf("cks%0d_w0", r), base_wr, 4'h0, 32'h1122_3344);
            chk($sformatf("cks%0d_busy", r), 32'(busy), 32'd0);
            chk($sformatf("cks%0d_err", r), 32'(rx_err), 32'(r));
        end
`endif
        chk("final_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- UART-driven program loader and run controller that sits directly upstream of the pipelined MIPS datapath.
- Deserialises bytes from the `rx` pin and decodes a small command protocol.
- Writes received instruction words into instruction memory through a dedicated write port.
- Drives the pipeline latch-enable `le` to halt, run or single-step the datapath.

Parameters:
- BAUD_DIV, 326, clk cycles per 16x oversample tick (50 MHz / (9600*16)); minimum 2.
- ADDR_W, 32, width of the instruction-memory byte address.
- CNT_W, 16, width of the LOAD word count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- rx  in  1  UART serial input, idle high; asynchronous to clk.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  byte address of the word being written; always a multiple of 4.
- imem_wdata  out  32  instruction word.
- le  out  1  pipeline latch enable to all stage latches (IF_ID, ID_EX, EX_MEM, MEM_WB).
- busy  out  1  high while a LOAD transfer is in progress.
- rx_err  out  1  sticky error flag; set on framing error or bad checksum.

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM in IDLE, word index 0, RX deserialiser idle.
- Input synchronisation: `rx` passes through a 2-flop synchroniser; tick counter free-runs at BAUD_DIV.
- RX deserialiser, start bit: detect a high-to-low edge on the synchronised `rx`, then re-sample at tick 8. If the line is back high, treat it as a glitch and return to RX idle.
- RX deserialiser, data and stop: sample 8 data bits LSB first, every 16 ticks. Then sample the stop bit.
  - Stop bit = 1: internal `byte_v` pulses for 1 cycle.
  - Stop bit = 0: byte discarded, rx_err set.
- Command FSM states: IDLE, CNT_HI, CNT_LO, DATA, CHK (macro only).
- IDLE byte decode:
  - 0x01 LOAD: le forced 0, busy=1, go to CNT_HI.
  - 0x02 RUN: le=1, held.
  - 0x03 STEP: le=1 for exactly one clk cycle, then 0.
  - 0x04 HALT: le=0.
  - 0x05 CLRERR: rx_err=0.
  - Any other byte: ignored, no state change.
- CNT_HI / CNT_LO: capture count N, MSB first, then go to DATA. If N=0, go straight to IDLE with busy=0.
- DATA: assemble each word from 4 bytes, MSB first.
  - The cycle after the 4th byte's `byte_v`: imem_we=1 for 1 cycle, imem_addr=4*index, imem_wdata=word. Then index increments.
  - After the Nth word: busy drops the same cycle as the last imem_we, index returns to 0, FSM goes to IDLE. le stays 0 until an explicit RUN or STEP.
- Address wrap: index is taken modulo 2^(ADDR_W-2).
- LOAD while running: le drops the cycle after `byte_v` of 0x01.
- STEP while le is already 1 (running): ignored.
- Framing error mid-LOAD: that byte is dropped and not counted. The transfer continues and rx_err stays set; the host must reissue the LOAD.
- Reset mid-operation: clears any partial word, the index, busy and le immediately.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the Nth word the FSM enters CHK and expects one byte equal to the XOR of all 4N data bytes. Count bytes are not included.
  - Match: IDLE, busy=0.
  - Mismatch: rx_err=1, then IDLE, busy=0.
  - Words are already written either way. With N=0 the checksum byte 0x00 is still expected.
- Undefined: no CHK state; LOAD ends after the Nth word.

Test Plan:
- Reset, then LOAD: send 0x01,0x00,0x02, then 0x20,0x08,0x00,0x05, 0x00,0x00,0x00,0x08 -> imem_we pulses twice: addr 0x0 data 0x20080005, addr 0x4 data 0x00000008. busy high from the 0x01 byte until the second write; le=0 throughout.
- Run control: send RUN (0x02) -> le=1 held; then STEP (0x03) -> ignored, le stays 1; then HALT (0x04) then STEP -> le=1 for exactly 1 clk, then 0.
- Frame with stop bit=0 carrying 0x02 -> rx_err=1, le stays 0; then send 0x05 -> rx_err=0.
- 0.3-bit-wide low glitch on rx, then 0x02 -> glitch rejected, le=1 after the valid frame only.
- reset=0 asserted after 2 of 4 data bytes of a LOAD -> all outputs 0 asynchronously. A fresh LOAD with N=1 then writes to addr 0x0.
- (LOADER_CHECKSUM_EN) LOAD N=1, word 0x11223344, checksum 0x44 -> rx_err=0. Repeat with checksum 0x45 -> rx_err=1.
